// File: rtl/bcd_time_keeper.sv
//------------------------------------------------------------------------------
// Module : bcd_time_keeper
// Brief  : Packed-BCD hh:mm:ss counter with a one-second prescaler and
//          checked field loads.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bcd_time_keeper #(
  parameter int TICK_DIV = 50000000,
  parameter int CNT_W    = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run_en,
  input  logic       set_en,
  input  logic       check_in,
  input  logic [2:0] h_m_s,
  input  logic [7:0] time_in,
  output logic [7:0] hours,
  output logic [7:0] minutes,
  output logic [7:0] seconds,
  output logic       sec_pulse,
  output logic       load_ack,
  output logic       load_err
);

  localparam logic [2:0]       c_sel_hours   = 3'b011;
  localparam logic [2:0]       c_sel_minutes = 3'b110;
  localparam logic [2:0]       c_sel_seconds = 3'b101;
  localparam logic [CNT_W-1:0] c_cnt_last    = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       hours_q, hours_d;
  logic [7:0]       minutes_q, minutes_d;
  logic [7:0]       seconds_q, seconds_d;
  logic             sec_pulse_q, sec_pulse_d;
  logic             load_ack_q, load_ack_d;
  logic             load_err_q, load_err_d;

  logic w_tick, w_adv;
  logic w_is_h, w_is_m, w_is_s;
  logic w_bcd_ok, w_range_ok, w_valid;
  logic w_ld_h, w_ld_m, w_ld_s;
  logic w_sec_wrap, w_min_wrap;

  // Wraps to 8'h00 at the field's last value; callers detect the carry.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
    if (v == last)
      return 8'h00;
    else if (v[3:0] == 4'h9)
      return {v[7:4] + 4'h1, 4'h0};
    else
      return {v[7:4], v[3:0] + 4'h1};
  endfunction

  always_comb begin
    w_tick = run_en && (cnt_q == c_cnt_last);

    w_is_h = (h_m_s == c_sel_hours);
    w_is_m = (h_m_s == c_sel_minutes);
    w_is_s = (h_m_s == c_sel_seconds);

    // Upstream flag is not trusted for BCD legality or range.
    w_bcd_ok   = (time_in[7:4] <= 4'h9) && (time_in[3:0] <= 4'h9);
    w_range_ok = (w_is_h && (time_in <= 8'h23)) ||
                 ((w_is_m || w_is_s) && (time_in <= 8'h59));
    w_valid    = check_in && w_bcd_ok && w_range_ok;

    w_ld_h = set_en && w_valid && w_is_h;
    w_ld_m = set_en && w_valid && w_is_m;
    w_ld_s = set_en && w_valid && w_is_s;

    // A seconds load swallows a coincident tick completely.
    w_adv      = w_tick && !w_ld_s;
    w_sec_wrap = (seconds_q == 8'h59);
    w_min_wrap = (minutes_q == 8'h59);

    cnt_d = cnt_q;
    if (run_en)
      cnt_d = w_tick ? '0 : cnt_q + CNT_W'(1);
    if (w_ld_s)
      cnt_d = '0;

    seconds_d = seconds_q;
    if (w_adv)
      seconds_d = bcd_inc(seconds_q, 8'h59);
    if (w_ld_s)
      seconds_d = time_in;

    minutes_d = minutes_q;
    if (w_adv && w_sec_wrap)
      minutes_d = bcd_inc(minutes_q, 8'h59);
    if (w_ld_m)
      minutes_d = time_in;

    hours_d = hours_q;
    if (w_adv && w_sec_wrap && w_min_wrap)
      hours_d = bcd_inc(hours_q, 8'h23);
    if (w_ld_h)
      hours_d = time_in;

    sec_pulse_d = w_adv;
    load_ack_d  = set_en && w_valid;
    load_err_d  = set_en && !w_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      hours_q     <= 8'h00;
      minutes_q   <= 8'h00;
      seconds_q   <= 8'h00;
      sec_pulse_q <= 1'b0;
      load_ack_q  <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      hours_q     <= hours_d;
      minutes_q   <= minutes_d;
      seconds_q   <= seconds_d;
      sec_pulse_q <= sec_pulse_d;
      load_ack_q  <= load_ack_d;
      load_err_q  <= load_err_d;
    end
  end

  assign hours     = hours_q;
  assign minutes   = minutes_q;
  assign seconds   = seconds_q;
  assign sec_pulse = sec_pulse_q;
  assign load_ack  = load_ack_q;
  assign load_err  = load_err_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_time_keeper.sv
//------------------------------------------------------------------------------
// Module : tb_bcd_time_keeper
// Brief  : Directed self-checking bench for bcd_time_keeper with TICK_DIV = 4.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bcd_time_keeper;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       run_en = 1'b0;
  logic       set_en = 1'b0;
  logic       check_in = 1'b0;
  logic [2:0] h_m_s = 3'b000;
  logic [7:0] time_in = 8'h00;
  logic [7:0] hours, minutes, seconds;
  logic       sec_pulse, load_ack, load_err;

  int n_pass  = 0;
  int n_total = 0;

  bcd_time_keeper #(.TICK_DIV(4), .CNT_W(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run_en   (run_en),
    .set_en   (set_en),
    .check_in (check_in),
    .h_m_s    (h_m_s),
    .time_in  (time_in),
    .hours    (hours),
    .minutes  (minutes),
    .seconds  (seconds),
    .sec_pulse(sec_pulse),
    .load_ack (load_ack),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_load(input logic chk, input logic [2:0] sel, input logic [7:0] val);
    set_en   = 1'b1;
    check_in = chk;
    h_m_s    = sel;
    time_in  = val;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({hours, minutes, seconds, sec_pulse, load_ack, load_err} !== 27'h0)
      $display("FAIL reset_async: got %h:%h:%h p=%b a=%b e=%b want all zero",
               hours, minutes, seconds, sec_pulse, load_ack, load_err);
    else n_pass++;
    run_en = 1'b1;
    step();
    step();
    n_total++;
    if ({hours, minutes, seconds, sec_pulse} !== 25'h0)
      $display("FAIL reset_hold: got %h:%h:%h p=%b want zero", hours, minutes, seconds, sec_pulse);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_count();
    int       t;
    logic [7:0] exp_s;
    for (int k = 1; k <= 40; k++) begin
      step();
      t     = k / 4;
      exp_s = {4'(t / 10), 4'(t % 10)};
      n_total++;
      if (seconds !== exp_s)
        $display("FAIL count_sec edge %0d: got %h want %h", k, seconds, exp_s);
      else n_pass++;
      n_total++;
      if (sec_pulse !== (k % 4 == 0))
        $display("FAIL count_pulse edge %0d: got %b want %b", k, sec_pulse, (k % 4 == 0));
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    drive_load(1'b1, 3'b011, 8'h23);
    step();
    n_total++;
    if (hours !== 8'h23 || load_ack !== 1'b1)
      $display("FAIL wrap_load_h: got %h ack=%b want 23 ack=1", hours, load_ack);
    else n_pass++;
    drive_load(1'b1, 3'b110, 8'h59);
    step();
    n_total++;
    if (minutes !== 8'h59 || load_ack !== 1'b1)
      $display("FAIL wrap_load_m: got %h ack=%b want 59 ack=1", minutes, load_ack);
    else n_pass++;
    drive_load(1'b1, 3'b101, 8'h58);
    step();
    set_en = 1'b0;
    n_total++;
    if (seconds !== 8'h58 || load_ack !== 1'b1 || load_err !== 1'b0)
      $display("FAIL wrap_load_s: got %h ack=%b err=%b want 58 1 0", seconds, load_ack, load_err);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      step();
      n_total++;
      if (seconds !== 8'h58 || sec_pulse !== 1'b0)
        $display("FAIL wrap_wait: got %h p=%b want 58 p=0", seconds, sec_pulse);
      else n_pass++;
    end
    step();
    n_total++;
    if ({hours, minutes, seconds} !== 24'h235959 || sec_pulse !== 1'b1)
      $display("FAIL wrap_235959: got %h:%h:%h p=%b want 23:59:59 p=1", hours, minutes, seconds, sec_pulse);
    else n_pass++;
    for (int k = 0; k < 4; k++) step();
    n_total++;
    if ({hours, minutes, seconds} !== 24'h000000 || sec_pulse !== 1'b1)
      $display("FAIL wrap_midnight: got %h:%h:%h p=%b want 00:00:00 p=1", hours, minutes, seconds, sec_pulse);
    else n_pass++;
  endtask

  task automatic test_load_err();
    logic [11:0] vec [4];
    vec[0] = {1'b1, 3'b011, 8'h1A};
    vec[1] = {1'b1, 3'b011, 8'h24};
    vec[2] = {1'b1, 3'b111, 8'h05};
    vec[3] = {1'b0, 3'b110, 8'h30};
    run_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_load(vec[i][11], vec[i][10:8], vec[i][7:0]);
      step();
      n_total++;
      if (load_err !== 1'b1 || load_ack !== 1'b0)
        $display("FAIL err_flag vec %0d: err=%b ack=%b want err=1 ack=0", i, load_err, load_ack);
      else n_pass++;
      n_total++;
      if ({hours, minutes, seconds} !== 24'h000000)
        $display("FAIL err_nochange vec %0d: got %h:%h:%h want 00:00:00", i, hours, minutes, seconds);
      else n_pass++;
    end
    set_en = 1'b0;
    step();
    n_total++;
    if (load_err !== 1'b0 || load_ack !== 1'b0)
      $display("FAIL err_idle: err=%b ack=%b want 0 0", load_err, load_ack);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    drive_load(1'b1, 3'b110, 8'h07);
    for (int k = 0; k < 2; k++) begin
      step();
      n_total++;
      if (load_ack !== 1'b1 || load_err !== 1'b0 || minutes !== 8'h07)
        $display("FAIL b2b_ack %0d: ack=%b err=%b min=%h want 1 0 07", k, load_ack, load_err, minutes);
      else n_pass++;
    end
    set_en = 1'b0;
    step();
    n_total++;
    if (load_ack !== 1'b0)
      $display("FAIL b2b_release: ack=%b want 0", load_ack);
    else n_pass++;
  endtask

  task automatic test_collision();
    run_en = 1'b1;
    drive_load(1'b1, 3'b101, 8'h10);
    step();
    set_en = 1'b0;
    for (int k = 0; k < 3; k++) step();
    drive_load(1'b1, 3'b101, 8'h45);
    step();
    set_en = 1'b0;
    n_total++;
    if (seconds !== 8'h45 || sec_pulse !== 1'b0 || load_ack !== 1'b1)
      $display("FAIL coll_sec: got %h p=%b ack=%b want 45 p=0 ack=1", seconds, sec_pulse, load_ack);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      step();
      n_total++;
      if (seconds !== 8'h45 || sec_pulse !== 1'b0)
        $display("FAIL coll_sec_wait %0d: got %h p=%b want 45 p=0", k, seconds, sec_pulse);
      else n_pass++;
    end
    step();
    n_total++;
    if (seconds !== 8'h46 || sec_pulse !== 1'b1)
      $display("FAIL coll_sec_next: got %h p=%b want 46 p=1", seconds, sec_pulse);
    else n_pass++;
    drive_load(1'b1, 3'b101, 8'h59);
    step();
    set_en = 1'b0;
    for (int k = 0; k < 3; k++) step();
    drive_load(1'b1, 3'b110, 8'h10);
    step();
    set_en = 1'b0;
    n_total++;
    if ({hours, minutes, seconds} !== 24'h001000 || sec_pulse !== 1'b1 || load_ack !== 1'b1)
      $display("FAIL coll_min: got %h:%h:%h p=%b ack=%b want 00:10:00 p=1 ack=1",
               hours, minutes, seconds, sec_pulse, load_ack);
    else n_pass++;
  endtask

  task automatic test_freeze_and_reset();
    step();
    step();
    run_en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      n_total++;
      if ({hours, minutes, seconds} !== 24'h001000 || sec_pulse !== 1'b0)
        $display("FAIL freeze %0d: got %h:%h:%h p=%b want 00:10:00 p=0", k, hours, minutes, seconds, sec_pulse);
      else n_pass++;
    end
    run_en = 1'b1;
    step();
    n_total++;
    if (seconds !== 8'h00 || sec_pulse !== 1'b0)
      $display("FAIL resume_hold: got %h p=%b want 00 p=0", seconds, sec_pulse);
    else n_pass++;
    step();
    n_total++;
    if (seconds !== 8'h01 || sec_pulse !== 1'b1)
      $display("FAIL resume_tick: got %h p=%b want 01 p=1", seconds, sec_pulse);
    else n_pass++;
    step();
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({hours, minutes, seconds, sec_pulse, load_ack, load_err} !== 27'h0)
      $display("FAIL midcount_reset: got %h:%h:%h p=%b a=%b e=%b want all zero",
               hours, minutes, seconds, sec_pulse, load_ack, load_err);
    else n_pass++;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_count();
    test_wrap();
    test_load_err();
    test_back_to_back();
    test_collision();
    test_freeze_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
